// File: rtl/exp_pkg.sv
// Shared constants for the sequence display controller: state codes, widths, default timings.
package exp_pkg;

    localparam int unsigned LARGURA_END  = 4;
    localparam int unsigned LARGURA_DADO = 4;

    localparam int unsigned T_ON_PADRAO  = 1000;
    localparam int unsigned T_OFF_PADRAO = 500;

    typedef logic [3:0] estado_t;

    // Codes also drive the hexa7seg debug display, so their values are fixed.
    localparam estado_t OCIOSO  = 4'd0;
    localparam estado_t CARREGA = 4'd1;
    localparam estado_t ACENDE  = 4'd2;
    localparam estado_t APAGA   = 4'd3;
    localparam estado_t PROXIMO = 4'd4;
    localparam estado_t FIM     = 4'd5;

    // ceil(log2(max(a, b))), never below 1 bit so a counter always exists.
    function automatic int unsigned largura_timer(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/controlador_exibicao_sequencia_if.sv
// Handshake with the game control unit plus the sequence-memory read port.
interface controlador_exibicao_sequencia_if;
    import exp_pkg::*;

    logic                    iniciar;
    logic                    abortar;
    logic [LARGURA_END-1:0]  limite;
    logic [LARGURA_DADO-1:0] dado;
    logic [LARGURA_END-1:0]  endereco;
    logic [LARGURA_DADO-1:0] leds;
    logic                    ocupado;
    logic                    pronto;
    estado_t                 db_estado;

    modport master (
        output iniciar,
        output abortar,
        output limite,
        output dado,
        input  endereco,
        input  leds,
        input  ocupado,
        input  pronto,
        input  db_estado
    );

    modport slave (
        input  iniciar,
        input  abortar,
        input  limite,
        input  dado,
        output endereco,
        output leds,
        output ocupado,
        output pronto,
        output db_estado
    );

endinterface

// File: rtl/contador_temporizador.sv
// Modulo counter: counts while `conta`, wraps and flags `fim` at the selected terminal value.
module contador_temporizador #(
    parameter int unsigned LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               zera,
    input  logic               conta,
    input  logic [LARGURA-1:0] terminal,
    output logic               fim
);

    logic [LARGURA-1:0] contagem_q;
    logic [LARGURA-1:0] contagem_d;

    assign fim = (contagem_q == terminal);

    always_comb begin
        contagem_d = contagem_q;
        if (zera) begin
            contagem_d = '0;
        end else if (conta) begin
            contagem_d = fim ? '0 : contagem_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            contagem_q <= '0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

endmodule

// File: rtl/controlador_exibicao_sequencia.sv
// Plays the stored sequence on the LEDs: each item lit for T_ON cycles, then blank for T_OFF.
module controlador_exibicao_sequencia
    import exp_pkg::*;
#(
    parameter int unsigned T_ON  = T_ON_PADRAO,
    parameter int unsigned T_OFF = T_OFF_PADRAO
) (
    input logic                             clock,
    input logic                             reset,
    controlador_exibicao_sequencia_if.slave sinais
);

    localparam int unsigned LARGURA_TIMER = largura_timer(T_ON, T_OFF);
    localparam logic [LARGURA_TIMER-1:0] TERMINAL_ON  = LARGURA_TIMER'(T_ON - 1);
    localparam logic [LARGURA_TIMER-1:0] TERMINAL_OFF = LARGURA_TIMER'(T_OFF - 1);

    if (T_ON < 1 || T_OFF < 1) begin : g_param_invalido
        $error("T_ON and T_OFF must both be at least 1");
    end

    estado_t                 estado_q, estado_d;
    logic [LARGURA_DADO-1:0] leds_q, leds_d;
    logic [LARGURA_END-1:0]  endereco_q, endereco_d;
    logic [LARGURA_END-1:0]  limite_q, limite_d;

    logic                     timer_conta;
    logic                     timer_zera;
    logic                     timer_fim;
    logic [LARGURA_TIMER-1:0] timer_terminal;

    // One shared timer: terminal follows the phase being timed.
    assign timer_conta    = (estado_q == ACENDE) || (estado_q == APAGA);
    assign timer_terminal = (estado_q == ACENDE) ? TERMINAL_ON : TERMINAL_OFF;
    assign timer_zera     = sinais.abortar || !timer_conta || timer_fim;

    contador_temporizador #(
        .LARGURA (LARGURA_TIMER)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .zera     (timer_zera),
        .conta    (timer_conta),
        .terminal (timer_terminal),
        .fim      (timer_fim)
    );

    always_comb begin
        estado_d   = estado_q;
        leds_d     = leds_q;
        endereco_d = endereco_q;
        limite_d   = limite_q;

        if (sinais.abortar) begin
            estado_d   = OCIOSO;
            leds_d     = '0;
            endereco_d = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    leds_d     = '0;
                    endereco_d = '0;
                    if (sinais.iniciar) begin
                        limite_d = sinais.limite;
                        estado_d = CARREGA;
                    end
                end
                CARREGA: begin
                    // Address has been stable a full cycle, so `dado` is valid here.
                    leds_d   = sinais.dado;
                    estado_d = ACENDE;
                end
                ACENDE: begin
                    if (timer_fim) begin
                        leds_d   = '0;
                        estado_d = APAGA;
                    end
                end
                APAGA: begin
                    if (timer_fim) begin
                        estado_d = PROXIMO;
                    end
                end
                PROXIMO: begin
                    // Compare before incrementing so limite=15 never wraps the address.
                    if (endereco_q == limite_q) begin
                        estado_d = FIM;
                    end else begin
                        endereco_d = endereco_q + 1'b1;
                        estado_d   = CARREGA;
                    end
                end
                FIM: begin
                    endereco_d = '0;
                    estado_d   = OCIOSO;
                end
                default: begin
                    leds_d     = '0;
                    endereco_d = '0;
                    estado_d   = OCIOSO;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            leds_q     <= '0;
            endereco_q <= '0;
            limite_q   <= '0;
        end else begin
            estado_q   <= estado_d;
            leds_q     <= leds_d;
            endereco_q <= endereco_d;
            limite_q   <= limite_d;
        end
    end

    assign sinais.leds      = leds_q;
    assign sinais.endereco  = endereco_q;
    assign sinais.db_estado = estado_q;
    assign sinais.ocupado   = (estado_q != OCIOSO);
    assign sinais.pronto    = (estado_q == FIM);

endmodule

// File: doc/controlador_exibicao_sequencia.md
# controlador_exibicao_sequencia

Sequencer that plays the stored game sequence on the LEDs before the player's turn. On `iniciar` it walks the sequence memory from address 0 to the latched `limite`. For each address it shows the stored 4-bit value on `leds` for T_ON cycles, then blanks the LEDs for T_OFF cycles. It sits between the game control unit, which issues `iniciar` and waits for `pronto`, and the datapath's sequence memory, which it drives through `endereco`/`dado`.

## Interface
- T_ON, default 1000: cycles each item stays lit; must be ≥1.
- T_OFF, default 500: blank cycles after each item; must be ≥1.
- clock, input, 1: single system clock, rising edge.
- reset, input, 1: synchronous, active-high; returns the block to OCIOSO.
- iniciar, input, 1: start request; sampled only in OCIOSO.
- abortar, input, 1: cancels playback; takes effect at the next edge.
- limite, input, 4: index of the last item to play; latched on start.
- dado, input, 4: memory read data; valid the cycle after `endereco` changes.
- endereco, output, 4: memory read address.
- leds, output, 4: LED pattern.
- ocupado, output, 1: high whenever the state is not OCIOSO.
- pronto, output, 1: one-cycle pulse when playback completes.
- db_estado, output, 4: state code for the hexa7seg debug display.

## Operation
- States and codes:
  - OCIOSO = 0
  - CARREGA = 1
  - ACENDE = 2
  - APAGA = 3
  - PROXIMO = 4
  - FIM = 5
- Unused codes go to OCIOSO.
- OCIOSO:
  - `leds` = 0, `endereco` = 0.
  - On `iniciar`=1: latch `limite` into `limite_reg`, go to CARREGA.
- CARREGA: holds `endereco` for one cycle so `dado` settles, then goes to ACENDE.
- CARREGA→ACENDE edge:
  - `leds` <= `dado`.
  - Timer cleared.
- ACENDE:
  - Timer counts each cycle.
  - When timer = T_ON-1, go to APAGA, set `leds` <= 0 and clear the timer.
- APAGA: when timer = T_OFF-1, go to PROXIMO.
- PROXIMO (one cycle):
  - If `endereco` = `limite_reg`, go to FIM.
  - Otherwise `endereco` <= `endereco`+1 and go to CARREGA.
- FIM:
  - `pronto` = 1 for exactly one cycle, then go to OCIOSO.
  - `endereco` returns to 0 on entering OCIOSO.
- `leds` is registered and never glitches.
- `pronto` and `ocupado` are decoded from the state.
- Timer width is ceil(log2(max(T_ON, T_OFF))).
- `endereco` is 4 bits and never wraps: with `limite`=15 the last item is 15, then FIM.
- Priority: reset > abortar > normal transitions.
  - `abortar` in any state: next state OCIOSO, `leds` = 0, `endereco` = 0, timer cleared, no `pronto`.
- `iniciar` with `abortar` in the same cycle in OCIOSO: `abortar` wins and the block stays idle.
- `iniciar` while `ocupado`: ignored; it neither restarts playback nor re-latches `limite`.
- Changes on `limite` during playback have no effect.
- Reset values:
  - State OCIOSO.
  - `leds` = 0, `endereco` = 0, `pronto` = 0, `ocupado` = 0, `db_estado` = 0.
  - Timer = 0, `limite_reg` = 0.

## Timing
- `iniciar` sampled at edge 0 → CARREGA after edge 0 (`ocupado` high); `leds` first show item 0 after edge 1.
- Per-item period is T_ON+T_OFF+2 cycles: CARREGA 1 + ACENDE T_ON + APAGA T_OFF + PROXIMO 1.
- With N = `limite`+1 items:
  - FIM is entered at edge N·(T_ON+T_OFF+2).
  - `pronto` is high for the following cycle.
  - OCIOSO is re-entered one edge later.
- Memory read latency tolerated: exactly 1 cycle (synchronous ROM).
- A new `iniciar` is accepted in the first OCIOSO cycle after FIM.

## Structure
- Shared package `exp_pkg` holds:
  - State code constants (OCIOSO..FIM, 4-bit).
  - Default T_ON/T_OFF values.
  - Address and data width constants (4).
- Sub-module `contador_temporizador`: parameterized modulo counter.
  - Inputs `zera` and `conta`.
  - Output `fim` = (count = M-1).
  - Instantiated once, with the terminal value selected by state (ACENDE → T_ON, APAGA → T_OFF).
- The rest is one FSM file. `db_estado` feeds the existing hexa7seg instance.

## Test plan
All scenarios use T_ON=4, T_OFF=2 (period 8), with memory preloaded 0:1, 1:2, 2:4, 3:8.
- Reset then idle 10 cycles → `leds`=0, `endereco`=0, `ocupado`=0, `pronto`=0, `db_estado`=0.
- `iniciar` pulse with `limite`=3 at edge 0:
  - `leds` = 1,2,4,8 each for 4 cycles, with 2 blank cycles between items.
  - Lit windows start after edges 1, 9, 17, 25.
  - `pronto` high only in the cycle after edge 32; `ocupado` low after edge 33.
- `limite`=0 → a single item `leds`=1 for 4 cycles; `pronto` after edge 8. `limite`=15 with a 16-entry memory → 16 items, `endereco` ends at 15 with no wrap.
- `abortar` during ACENDE of item 2 → next edge state 0, `leds`=0, `endereco`=0, no `pronto`. Then a fresh `iniciar` plays from item 0.
- `iniciar` re-pulsed mid-playback with `limite` changed to 1 → ignored; all 4 items play.
- `iniciar` and `abortar` together in OCIOSO → block stays idle.
- Reset asserted mid-APAGA → all outputs return to reset values at the next edge.
